// File: rtl/qlf_k6n10_mp_add_seq_pkg.sv
// Shared definitions for the qlf_k6n10 multi-precision arithmetic sequencer:
// sequencer state encoding and the shortest usable hard carry chain.
package qlf_k6n10_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int unsigned MIN_CHAIN_WIDTH = 3;

    function automatic logic chain_width_ok(input int unsigned width);
        return (width >= MIN_CHAIN_WIDTH);
    endfunction

endpackage

// File: rtl/qlf_k6n10_word_adder.sv
// One DATA_WIDTH-bit slice of the hard carry chain, built from adder_carry cells
// (propagate p = a ^ b, generate g = a). cmsb is the carry into the top bit.
module adder_carry (
    input  logic p,
    input  logic g,
    input  logic cin,
    output logic sumout,
    output logic cout
);
    assign sumout = p ^ cin;
    assign cout   = p ? cin : g;
endmodule

module qlf_k6n10_word_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  cmsb
);
    logic [DATA_WIDTH:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cell
        adder_carry u_cell (
            .p      (a[i] ^ b[i]),
            .g      (a[i]),
            .cin    (carry_s[i]),
            .sumout (sum[i]),
            .cout   (carry_s[i+1])
        );
    end

    assign cout = carry_s[DATA_WIDTH];
    assign cmsb = carry_s[DATA_WIDTH-1];
endmodule

// File: rtl/qlf_k6n10_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams NUM_WORDS operand words LSW first
// through one word-wide carry-chain slice, carrying between words in a register.
module qlf_k6n10_mp_add_seq
    import qlf_k6n10_arith_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  ci,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_last,
    output logic                  out_co,
    output logic                  out_ovf,
    output logic                  done
);
    localparam int unsigned CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

    if (!chain_width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("qlf_k6n10_mp_add_seq: DATA_WIDTH is shorter than the minimum chain width");
    end
    if (NUM_WORDS < 1) begin : g_bad_words
        $error("qlf_k6n10_mp_add_seq: NUM_WORDS must be at least 1");
    end

    seq_state_e            state_q;
    logic [CW-1:0]         cnt_q;
    logic                  carry_q;
    logic                  sub_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_y_q;
    logic                  out_last_q;
    logic                  out_co_q;
    logic                  out_ovf_q;

    logic [DATA_WIDTH-1:0] bb_s;
    logic [DATA_WIDTH-1:0] sum_s;
    logic                  cout_s;
    logic                  cmsb_s;
    logic                  accept_s;
    logic                  take_s;
    logic                  is_last_s;
    logic [CW-1:0]         cnt_d;

    assign bb_s      = sub_q ? ~in_b : in_b;
    assign in_ready  = (state_q == RUN) & (~out_valid_q | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign take_s    = out_valid_q & out_ready;
    assign is_last_s = (cnt_q == LAST_CNT);
    assign cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    qlf_k6n10_word_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_adder (
        .a    (in_a),
        .b    (bb_s),
        .cin  (carry_q),
        .sum  (sum_s),
        .cout (cout_s),
        .cmsb (cmsb_s)
    );

    // Sequencer FSM, word counter, inter-word carry and the single output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= {DATA_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_co_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            // A new word may enter in the same cycle the held word leaves.
            if (accept_s) begin
                out_valid_q <= 1'b1;
                out_y_q     <= sum_s;
                out_last_q  <= is_last_s;
                out_co_q    <= is_last_s & cout_s;
                out_ovf_q   <= is_last_s & (cout_s ^ cmsb_s);
                carry_q     <= cout_s;
                cnt_q       <= cnt_d;
            end else if (take_s) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_co_q    <= 1'b0;
                out_ovf_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        sub_q   <= sub;
                        carry_q <= ci;
                        cnt_q   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    if (accept_s && is_last_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (take_s && out_last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;
    assign out_co    = out_co_q;
    assign out_ovf   = out_ovf_q;
    assign done      = take_s & out_last_q;
endmodule
